muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 19 +
 rtl/adder_sub.sv | 19 +
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/adder_sub.sv
// Combinational add/subtract (operation_i = 1 subtracts); latency 0, no flow control.
module adder_sub #(
  parameter int WORDSIZE = 8
) (
  input  logic [WORDSIZE-1:0] a_i,
  input  logic [WORDSIZE-1:0] b_i,
  input  logic                operation_i,
  output logic [WORDSIZE-1:0] result_o,
  output logic                overflow_o
);

  logic [WORDSIZE-1:0] b_eff;

  assign b_eff      = operation_i ? ~b_i : b_i;
  assign result_o   = a_i + b_eff + {{(WORDSIZE-1){1'b0}}, operation_i};
  assign overflow_o = (a_i[WORDSIZE-1] == b_eff[WORDSIZE-1]) &&
                      (result_o[WORDSIZE-1] != a_i[WORDSIZE-1]);

endmodule

// File: rtl/muldiv_sequencer.sv
// Unsigned MUL/MULHU/DIVU/REMU, one shared adder step per cycle; result after WORDSIZE+1 cycles, held until out_ready.
// MULDIV_EARLY_OUT_EN: zero divisor or zero multiplicand skips straight to DONE (latency 1).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [WORDSIZE-1:0] operand_a,
  input  logic [WORDSIZE-1:0] operand_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] result,
  output logic                busy
);

  localparam int CW = $clog2(WORDSIZE) + 1;
  localparam int AW = WORDSIZE + 2;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WORDSIZE-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [AW-1:0]       add_a, add_b, add_res;
  logic                add_sub;
  logic                adder_ovf_unused;
  logic [WORDSIZE:0]   div_s;
  logic                accept;
`ifdef MULDIV_EARLY_OUT_EN
  logic                early;
`endif

  // hi/lo double as remainder/quotient during a divide
  assign div_s   = {hi_q, lo_q[WORDSIZE-1]};
  assign add_sub = is_div(op_q);

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (add_sub) begin
      add_a = {1'b0, div_s};
      add_b = {2'b00, opb_q};
    end else begin
      add_a = {2'b00, hi_q};
      add_b = lo_q[0] ? {2'b00, opb_q} : '0;
    end
  end

  adder_sub #(.WORDSIZE(AW)) u_adder_sub (
    .a_i         (add_a),
    .b_i         (add_b),
    .operation_i (add_sub),
    .result_o    (add_res),
    .overflow_o  (adder_ovf_unused)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign result    = op_q[0] ? hi_q : lo_q;  // MULHU/REMU take hi, MUL/DIVU take lo

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (operand_b == '0) ||
                 (((op == OP_MUL) || (op == OP_MULHU)) && (operand_a == '0));
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          opb_d   = operand_b;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = operand_a;
          state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_d = DONE;
            if (is_div(op)) begin
              lo_d = '1;
              hi_d = operand_a;
            end else begin
              lo_d = '0;
            end
          end
`endif
        end
      end
      CALC: begin
        if (add_sub) begin
          if (!add_res[AW-1]) begin
            hi_d = add_res[WORDSIZE-1:0];
            lo_d = {lo_q[WORDSIZE-2:0], 1'b1};
          end else begin
            hi_d = div_s[WORDSIZE-1:0];
            lo_d = {lo_q[WORDSIZE-2:0], 1'b0};
          end
        end else begin
          hi_d = add_res[WORDSIZE:1];
          lo_d = {add_res[0], lo_q[WORDSIZE-1:1]};
        end
        if (cnt_q == CW'(WORDSIZE - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
